// File: rtl/clk_switch_sequencer.sv
// Glitch-safe HDMI/local clock switchover sequencer running on the always-present local clock.
// Define SWITCH_STATS_EN to add the switch_cnt / retry_cnt statistics outputs.
module clk_switch_sequencer #(
   parameter int unsigned DEBOUNCE_CYC = 1024,
   parameter int unsigned QUIESCE_CYC  = 64,
   parameter int unsigned MMCM_RST_CYC = 16,
   parameter int unsigned LOCK_TIMEOUT = 1000000,
   parameter int unsigned SETTLE_CYC   = 256,
   parameter int unsigned CNT_W        = 20
) (
   input  logic        local_clk,
   input  logic        rst_n,
   input  logic        sel_in,
   input  logic        mmcm_locked,
   output logic        clk_sel,
   output logic        mmcm_rst,
   output logic        pipe_rst_n,
   output logic        busy,
   output logic        lock_retry
`ifdef SWITCH_STATS_EN
   ,
   output logic [15:0] switch_cnt,
   output logic [7:0]  retry_cnt
`endif
);

   typedef enum logic [2:0] {
      StInit,
      StRun,
      StQuiesce,
      StSwap,
      StWaitLock,
      StSettle
   } state_e;

   localparam logic [CNT_W-1:0] DebounceLast = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] QuiesceLoad  = CNT_W'(QUIESCE_CYC - 1);
   localparam logic [CNT_W-1:0] MmcmRstLoad  = CNT_W'(MMCM_RST_CYC - 1);
   localparam logic [CNT_W-1:0] LockLoad     = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] SettleLoad   = CNT_W'(SETTLE_CYC - 1);

   logic             sel_meta_q, sel_s_q;
   logic             lock_meta_q, lock_s_q;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             clk_sel_q, clk_sel_d;
   logic             mmcm_rst_q, mmcm_rst_d;
   logic             pipe_rst_n_q, pipe_rst_n_d;
   logic             busy_q, busy_d;
   logic             lock_retry_q, lock_retry_d;
   logic             lock_low_q, lock_low_d;
   logic             toggle_q, toggle_d;
   logic             sw_pend_q, sw_pend_d;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      clk_sel_d    = clk_sel_q;
      mmcm_rst_d   = mmcm_rst_q;
      pipe_rst_n_d = pipe_rst_n_q;
      lock_retry_d = 1'b0;
      lock_low_d   = 1'b0;
      toggle_d     = toggle_q;
      sw_pend_d    = sw_pend_q;

      unique case (state_q)
         StInit: begin
            if (cnt_q == '0) begin
               state_d    = StWaitLock;
               mmcm_rst_d = 1'b0;
               cnt_d      = LockLoad;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         StRun: begin
            lock_low_d = ~lock_s_q;
            // Two consecutive low lock samples force a re-lock sequence without a source change.
            if (!lock_s_q && lock_low_q) begin
               state_d      = StQuiesce;
               pipe_rst_n_d = 1'b0;
               cnt_d        = QuiesceLoad;
               toggle_d     = 1'b0;
               sw_pend_d    = 1'b1;
               lock_low_d   = 1'b0;
            end else if (sel_s_q != clk_sel_q) begin
               if (cnt_q == DebounceLast) begin
                  state_d      = StQuiesce;
                  pipe_rst_n_d = 1'b0;
                  cnt_d        = QuiesceLoad;
                  toggle_d     = 1'b1;
                  sw_pend_d    = 1'b1;
                  lock_low_d   = 1'b0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else begin
               cnt_d = '0;
            end
         end

         StQuiesce: begin
            if (cnt_q == '0) begin
               state_d    = StSwap;
               mmcm_rst_d = 1'b1;
               cnt_d      = MmcmRstLoad;
               if (toggle_q) begin
                  clk_sel_d = ~clk_sel_q;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         StSwap: begin
            if (cnt_q == '0) begin
               state_d    = StWaitLock;
               mmcm_rst_d = 1'b0;
               cnt_d      = LockLoad;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         StWaitLock: begin
            if (lock_s_q) begin
               state_d = StSettle;
               cnt_d   = SettleLoad;
            end else if (cnt_q == '0) begin
               // Retry re-enters SWAP only to pulse the MMCM reset; clk_sel is left alone.
               state_d      = StSwap;
               mmcm_rst_d   = 1'b1;
               lock_retry_d = 1'b1;
               cnt_d        = MmcmRstLoad;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         StSettle: begin
            if (!lock_s_q) begin
               state_d = StWaitLock;
               cnt_d   = LockLoad;
            end else if (cnt_q == '0) begin
               state_d      = StRun;
               pipe_rst_n_d = 1'b1;
               cnt_d        = '0;
               sw_pend_d    = 1'b0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         default: begin
            state_d      = StInit;
            cnt_d        = MmcmRstLoad;
            clk_sel_d    = 1'b1;
            mmcm_rst_d   = 1'b1;
            pipe_rst_n_d = 1'b0;
            sw_pend_d    = 1'b0;
         end
      endcase

      busy_d = (state_d != StRun);
   end

   always_ff @(posedge local_clk) begin
      if (!rst_n) begin
         sel_meta_q   <= 1'b0;
         sel_s_q      <= 1'b0;
         lock_meta_q  <= 1'b0;
         lock_s_q     <= 1'b0;
         state_q      <= StInit;
         cnt_q        <= MmcmRstLoad;
         clk_sel_q    <= 1'b1;
         mmcm_rst_q   <= 1'b1;
         pipe_rst_n_q <= 1'b0;
         busy_q       <= 1'b1;
         lock_retry_q <= 1'b0;
         lock_low_q   <= 1'b0;
         toggle_q     <= 1'b0;
         sw_pend_q    <= 1'b0;
      end else begin
         sel_meta_q   <= sel_in;
         sel_s_q      <= sel_meta_q;
         lock_meta_q  <= mmcm_locked;
         lock_s_q     <= lock_meta_q;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         clk_sel_q    <= clk_sel_d;
         mmcm_rst_q   <= mmcm_rst_d;
         pipe_rst_n_q <= pipe_rst_n_d;
         busy_q       <= busy_d;
         lock_retry_q <= lock_retry_d;
         lock_low_q   <= lock_low_d;
         toggle_q     <= toggle_d;
         sw_pend_q    <= sw_pend_d;
      end
   end

   assign clk_sel    = clk_sel_q;
   assign mmcm_rst   = mmcm_rst_q;
   assign pipe_rst_n = pipe_rst_n_q;
   assign busy       = busy_q;
   assign lock_retry = lock_retry_q;

`ifdef SWITCH_STATS_EN
   logic [15:0] switch_cnt_q, switch_cnt_d;
   logic [7:0]  retry_cnt_q, retry_cnt_d;

   // A switch completes on the SETTLE->RUN edge; the power-up INIT sequence does not count.
   always_comb begin
      switch_cnt_d = switch_cnt_q;
      retry_cnt_d  = retry_cnt_q;
      if (state_q == StSettle && state_d == StRun && sw_pend_q && switch_cnt_q != 16'hFFFF) begin
         switch_cnt_d = switch_cnt_q + 16'd1;
      end
      if (lock_retry_d && retry_cnt_q != 8'hFF) begin
         retry_cnt_d = retry_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge local_clk) begin
      if (!rst_n) begin
         switch_cnt_q <= 16'd0;
         retry_cnt_q  <= 8'd0;
      end else begin
         switch_cnt_q <= switch_cnt_d;
         retry_cnt_q  <= retry_cnt_d;
      end
   end

   assign switch_cnt = switch_cnt_q;
   assign retry_cnt  = retry_cnt_q;
`endif

endmodule

// File: tb/tb_clk_switch_sequencer.sv
// Scoreboard bench for clk_switch_sequencer: every expected output change (edge number and value)
// is queued by the stimulus, and a negedge monitor pops and compares on each observed change.
module tb_clk_switch_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sel_in;
   logic        mmcm_locked;
   logic        clk_sel;
   logic        mmcm_rst;
   logic        pipe_rst_n;
   logic        busy;
   logic        lock_retry;
   logic [28:0] obs;

`ifdef SWITCH_STATS_EN
   logic [15:0] switch_cnt;
   logic [7:0]  retry_cnt;
   localparam logic [28:0] Mask = '1;
   assign obs = {switch_cnt, retry_cnt, clk_sel, mmcm_rst, pipe_rst_n, busy, lock_retry};
`else
   localparam logic [28:0] Mask = 29'h1F;
   assign obs = {24'h0, clk_sel, mmcm_rst, pipe_rst_n, busy, lock_retry};
`endif

   clk_switch_sequencer #(
      .DEBOUNCE_CYC (8),
      .QUIESCE_CYC  (4),
      .MMCM_RST_CYC (2),
      .LOCK_TIMEOUT (20),
      .SETTLE_CYC   (4),
      .CNT_W        (20)
   ) dut (
      .local_clk   (clk),
      .rst_n       (rst_n),
      .sel_in      (sel_in),
      .mmcm_locked (mmcm_locked),
      .clk_sel     (clk_sel),
      .mmcm_rst    (mmcm_rst),
      .pipe_rst_n  (pipe_rst_n),
      .busy        (busy),
`ifdef SWITCH_STATS_EN
      .lock_retry  (lock_retry),
      .switch_cnt  (switch_cnt),
      .retry_cnt   (retry_cnt)
`else
      .lock_retry  (lock_retry)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [28:0] val;
   } ev_t;

   ev_t exp_q[$];
   int  edge_n = 0;
   int  n_chk  = 0;
   int  n_pass = 0;
   int  n_ev   = 0;

   // Output vector order: {clk_sel, mmcm_rst, pipe_rst_n, busy, lock_retry}
   task automatic push(input int cyc, input logic [4:0] o, input logic [15:0] sw,
                       input logic [7:0] rt);
      ev_t e;
      e.cyc = cyc;
      e.val = {sw, rt, o} & Mask;
      exp_q.push_back(e);
   endtask

   task automatic wait_to(input int k);
      while (edge_n < k) @(negedge clk);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         edge_n++;
      end
   end

   initial begin
      logic [28:0] prev;
      ev_t         e;
      prev = 'x;
      forever begin
         @(negedge clk);
         if (obs !== prev) begin
            n_chk++;
            n_ev++;
            if (exp_q.size() == 0) begin
               $display("FAIL ev%0d unexpected: got cyc %0d val %h, want no change",
                        n_ev, edge_n, obs);
            end else begin
               e = exp_q.pop_front();
               if (e.cyc != edge_n || obs !== e.val) begin
                  $display("FAIL ev%0d: got cyc %0d val %h, want cyc %0d val %h",
                           n_ev, edge_n, obs, e.cyc, e.val);
               end else begin
                  n_pass++;
               end
            end
            prev = obs;
         end
      end
   end

   initial begin
      int b, c, d, e, f, g;
      rst_n       = 1'b0;
      sel_in      = 1'b1;
      mmcm_locked = 1'b1;

      // Reset and power-up lock
      push(1, 5'b11010, 16'd0, 8'd0);
      push(4, 5'b10010, 16'd0, 8'd0);
      push(9, 5'b10100, 16'd0, 8'd0);
      wait_to(2);
      rst_n = 1'b1;

      // 5-cycle select glitch: debounce never completes, no output change
      wait_to(12);
      sel_in = 1'b0;
      wait_to(17);
      sel_in = 1'b1;

      // Steady switch 1->0
      b = 24;
      wait_to(b);
      push(b + 10, 5'b10010, 16'd0, 8'd0);
      push(b + 14, 5'b01010, 16'd0, 8'd0);
      push(b + 16, 5'b00010, 16'd0, 8'd0);
      push(b + 21, 5'b00100, 16'd1, 8'd0);
      sel_in = 1'b0;

      // Switch 0->1 with lock lost from QUIESCE: two timeouts, then lock returns
      c = 50;
      wait_to(c);
      push(c + 10, 5'b00010, 16'd1, 8'd0);
      push(c + 14, 5'b11010, 16'd1, 8'd0);
      push(c + 16, 5'b10010, 16'd1, 8'd0);
      push(c + 36, 5'b11011, 16'd1, 8'd1);
      push(c + 37, 5'b11010, 16'd1, 8'd1);
      push(c + 38, 5'b10010, 16'd1, 8'd1);
      push(c + 58, 5'b11011, 16'd1, 8'd2);
      push(c + 59, 5'b11010, 16'd1, 8'd2);
      push(c + 60, 5'b10010, 16'd1, 8'd2);
      push(c + 68, 5'b10100, 16'd2, 8'd2);
      sel_in = 1'b1;
      wait_to(c + 11);
      mmcm_locked = 1'b0;
      wait_to(c + 61);
      mmcm_locked = 1'b1;

      // Switch 1->0 with a 1-cycle lock drop during SETTLE: SETTLE restarts in full
      d = 122;
      wait_to(d);
      push(d + 10, 5'b10010, 16'd2, 8'd2);
      push(d + 14, 5'b01010, 16'd2, 8'd2);
      push(d + 16, 5'b00010, 16'd2, 8'd2);
      push(d + 25, 5'b00100, 16'd3, 8'd2);
      sel_in = 1'b0;
      wait_to(d + 17);
      mmcm_locked = 1'b0;
      wait_to(d + 18);
      mmcm_locked = 1'b1;

      // 1-cycle lock drop in RUN is tolerated
      g = 150;
      wait_to(g);
      mmcm_locked = 1'b0;
      wait_to(g + 1);
      mmcm_locked = 1'b1;

      // 3-cycle lock drop in RUN: re-lock sequence without toggling clk_sel
      e = 158;
      wait_to(e);
      push(e + 4, 5'b00010, 16'd3, 8'd2);
      push(e + 8, 5'b01010, 16'd3, 8'd2);
      push(e + 10, 5'b00010, 16'd3, 8'd2);
      push(e + 15, 5'b00100, 16'd4, 8'd2);
      mmcm_locked = 1'b0;
      wait_to(e + 3);
      mmcm_locked = 1'b1;

      // Reset in the middle of QUIESCE
      f = 178;
      wait_to(f);
      push(f + 10, 5'b00010, 16'd4, 8'd2);
      push(f + 12, 5'b11010, 16'd0, 8'd0);
      push(f + 15, 5'b10010, 16'd0, 8'd0);
      push(f + 20, 5'b10100, 16'd0, 8'd0);
      sel_in = 1'b1;
      wait_to(f + 11);
      rst_n = 1'b0;
      wait_to(f + 13);
      rst_n = 1'b1;

      wait_to(215);
      n_chk++;
      if (exp_q.size() == 0) begin
         n_pass++;
      end else begin
         $display("FAIL pending: got %0d unseen events, want 0 (next cyc %0d val %h)",
                  exp_q.size(), exp_q[0].cyc, exp_q[0].val);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
